// File: rtl/router_pkg.sv
// Shared definitions for the router read-side scheduler: FSM states, header
// field positions and the output-buffer entry layout.
package router_pkg;

   localparam int LEN_W        = 6;
   localparam int NUM_PORTS    = 3;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_ADDR_MSB = 1;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] HDR      = 3'd1;
   localparam logic [2:0] WAIT_HDR = 3'd2;
   localparam logic [2:0] BODY     = 3'd3;
   localparam logic [2:0] DRAIN    = 3'd4;

   typedef struct packed {
      logic [1:0] port;
      logic       eop;
      logic       sop;
      logic [7:0] data;
   } buf_entry_t;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // First set valid at or after ptr, wrapping 2 -> 0.
   function automatic logic [1:0] rr_pick(input logic [2:0] vld, input logic [1:0] ptr);
      logic [1:0] cand;
      logic [1:0] pick;
      logic       found;
      cand  = ptr;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (vld[cand] && !found) begin
            pick  = cand;
            found = 1'b1;
         end
         cand = next_port(cand);
      end
      return pick;
   endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry output buffer holding {port, eop, sop, data}; flush empties it at once
// and wins over a concurrent push.
module router_skid_buf
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  buf_entry_t push_entry,
   input  logic       pop,
   input  logic       flush,
   output buf_entry_t head,
   output logic       valid,
   output logic [1:0] occ
);

   buf_entry_t mem_reg [2];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] occ_reg;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop && (occ_reg != 2'd0);
   assign do_push = push && ((occ_reg != 2'd2) || do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               mem_reg[gi] <= '0;
            end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
               mem_reg[gi] <= push_entry;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else if (flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         occ_reg <= occ_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign valid = (occ_reg != 2'd0);
   assign occ   = occ_reg;

endmodule

// File: rtl/router_rd_sched.sv
// Read-side scheduler: packet-granular round-robin over three router output FIFOs,
// merging them into one framed ready/valid byte stream with parity checking.
module router_rd_sched
   import router_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 32,
   parameter int TW      = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [2:0]    vld_in,
   input  logic [DW-1:0] data_in_0,
   input  logic [DW-1:0] data_in_1,
   input  logic [DW-1:0] data_in_2,
   output logic          read_enb_0,
   output logic          read_enb_1,
   output logic          read_enb_2,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_sop,
   output logic          m_eop,
   output logic [1:0]    m_port,
   output logic          pkt_err,
   output logic          abort
);

   logic [DW-1:0]  data_arr [NUM_PORTS];
   logic [2:0]     state_reg, state_next;
   logic [1:0]     grant_reg, grant_next;
   logic [1:0]     ptr_reg, ptr_next;
   logic [LEN_W:0] rem_reg, rem_next;
   logic [TW-1:0]  to_cnt_reg, to_cnt_next;
   logic [DW-1:0]  acc_reg, acc_next;
   logic           err_reg, err_next;
   logic           abort_reg, abort_next;
   logic           rd_pend_reg, pend_sop_reg, pend_eop_reg;

   logic           active, vld_g, pop, buf_room, reads_left;
   logic           timeout_hit, issue, push, flush;
   logic [DW-1:0]  data_sel;
   logic [2:0]     rd_vec;
   buf_entry_t     push_entry, head;
   logic           buf_valid;
   logic [1:0]     buf_occ;

   assign data_arr[0] = data_in_0;
   assign data_arr[1] = data_in_1;
   assign data_arr[2] = data_in_2;
   assign data_sel    = data_arr[grant_reg];

   assign active      = (state_reg == HDR) || (state_reg == BODY);
   assign vld_g       = vld_in[grant_reg];
   assign pop         = buf_valid && m_ready;
   // A read now lands in the buffer next cycle; keep one slot for it.
   assign buf_room    = ({1'b0, buf_occ} + {2'b00, rd_pend_reg}) <= (3'd1 + {2'b00, pop});
   assign reads_left  = (state_reg == HDR) || ((state_reg == BODY) && (rem_reg != '0));
   assign timeout_hit = active && !vld_g && (to_cnt_reg == TW'(TIMEOUT - 1));
   assign issue       = active && reads_left && vld_g && buf_room;
   assign push        = rd_pend_reg && !timeout_hit;

   assign push_entry.port = grant_reg;
   assign push_entry.eop  = pend_eop_reg;
   assign push_entry.sop  = pend_sop_reg;
   assign push_entry.data = data_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
         assign rd_vec[gi] = issue && (grant_reg == 2'(gi));
      end
   endgenerate

   assign read_enb_0 = rd_vec[0];
   assign read_enb_1 = rd_vec[1];
   assign read_enb_2 = rd_vec[2];

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      ptr_next    = ptr_reg;
      rem_next    = rem_reg;
      acc_next    = acc_reg;
      err_next    = err_reg;
      abort_next  = 1'b0;
      flush       = 1'b0;
      to_cnt_next = active ? (vld_g ? '0 : to_cnt_reg + TW'(1)) : '0;

      case (state_reg)
         IDLE: begin
            if (|vld_in) begin
               grant_next = rr_pick(vld_in, ptr_reg);
               state_next = HDR;
            end
         end
         HDR: begin
            if (issue) state_next = WAIT_HDR;
         end
         WAIT_HDR: begin
            rem_next   = {1'b0, data_sel[HDR_LEN_MSB:HDR_LEN_LSB]} + (LEN_W + 1)'(1);
            state_next = BODY;
         end
         BODY: begin
            if (issue) begin
               rem_next = rem_reg - (LEN_W + 1)'(1);
               if (rem_reg == (LEN_W + 1)'(1)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Re-arbitrate in the same cycle the eop byte leaves the buffer.
            if (pop && head.eop) begin
               ptr_next = next_port(grant_reg);
               if (|vld_in) begin
                  grant_next = rr_pick(vld_in, next_port(grant_reg));
                  state_next = HDR;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (timeout_hit) begin
         state_next  = IDLE;
         ptr_next    = next_port(grant_reg);
         abort_next  = 1'b1;
         flush       = 1'b1;
         to_cnt_next = '0;
      end

      if (push) begin
         if (pend_sop_reg)      acc_next = data_sel;
         else if (pend_eop_reg) err_next = (acc_reg != data_sel);
         else                   acc_next = acc_reg ^ data_sel;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_reg    <= 2'd0;
         ptr_reg      <= 2'd0;
         rem_reg      <= '0;
         to_cnt_reg   <= '0;
         acc_reg      <= '0;
         err_reg      <= 1'b0;
         abort_reg    <= 1'b0;
         rd_pend_reg  <= 1'b0;
         pend_sop_reg <= 1'b0;
         pend_eop_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         ptr_reg      <= ptr_next;
         rem_reg      <= rem_next;
         to_cnt_reg   <= to_cnt_next;
         acc_reg      <= acc_next;
         err_reg      <= err_next;
         abort_reg    <= abort_next;
         rd_pend_reg  <= issue;
         pend_sop_reg <= issue && (state_reg == HDR);
         pend_eop_reg <= issue && (state_reg == BODY) && (rem_reg == (LEN_W + 1)'(1));
      end
   end

   router_skid_buf u_buf (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .head       (head),
      .valid      (buf_valid),
      .occ        (buf_occ)
   );

   assign m_valid = buf_valid;
   assign m_data  = head.data;
   assign m_sop   = head.sop;
   assign m_eop   = head.eop;
   assign m_port  = head.port;
   assign pkt_err = buf_valid && head.eop && err_reg;
   assign abort   = abort_reg;

endmodule

// File: doc/router_rd_sched.md
Name: router_rd_sched

Overview:
Read-side scheduler for the 1x3 router.
- Watches the three output-port valids and drives the three read enables.
- Arbitrates round-robin at packet granularity, so a granted port is drained header-to-parity before the grant moves.
- Merges the three byte streams into one ready/valid output with packet framing and a parity check.
- Sits between the router outputs and a single downstream consumer (DMA/host bridge).

Parameters:
- DW, 8, data byte width (fixed by packet format).
- TIMEOUT, 32, cycles the granted port may stay not-valid mid-packet before the packet is aborted.
- TW, 6, timeout counter width; TIMEOUT must be < 2**TW.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- vld_in  in  3  router output valids; bit i = port i FIFO non-empty.
- data_in_0  in  8  router port 0 read data; valid one cycle after read_enb_0.
- data_in_1  in  8  router port 1 read data; same timing.
- data_in_2  in  8  router port 2 read data; same timing.
- read_enb_0  out  1  read strobe to port 0 FIFO.
- read_enb_1  out  1  read strobe to port 1 FIFO.
- read_enb_2  out  1  read strobe to port 2 FIFO.
- m_data  out  8  merged output byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept; transfer when m_valid && m_ready.
- m_sop  out  1  current m_data is a header byte.
- m_eop  out  1  current m_data is a parity byte.
- m_port  out  2  source port of current byte.
- pkt_err  out  1  parity mismatch, qualified by m_valid && m_eop.
- abort  out  1  one-cycle pulse when a packet is abandoned on timeout.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE, round-robin pointer = port 0, buffer empty, all counters 0.
- Packet format: header[7:2] = payload length L (0..63), header[1:0] = address; then L payload bytes; then 1 parity byte. Bytes per packet = L+2.
- Parity check: XOR of header and all payload bytes must equal the parity byte. Mismatch sets pkt_err on the eop beat.
- FIFO read timing: read_enb_i high in cycle N gives the byte on data_in_i in cycle N+1. Captured data is written into a 2-entry output buffer.
- Only the granted port's read_enb may be high; at most one read_enb is high in any cycle.
- Issue rule: read allowed in cycle N iff
  - vld_in[grant]=1,
  - reads remain for the packet,
  - (occupancy + pending − pop) ≤ 1, where pending = read issued in N−1 and pop = m_valid && m_ready.
  This gives 1 byte/cycle with m_ready high and never overflows the buffer.
- State machine:
  - IDLE:
    - If any vld_in is set, grant the first set bit at or after the pointer (wrapping 2→0) and go to HDR.
    - Arbitration costs one cycle; grant registered.
  - HDR: issue exactly one read when the issue rule allows, then go to WAIT_HDR.
  - WAIT_HDR: capture the header byte (cycle after read), load the remaining count with L+1, go to BODY.
  - BODY:
    - Issue reads until the remaining count reaches 0.
    - When the last read has been issued, go to DRAIN.
  - DRAIN:
    - When the eop byte has been popped from the buffer, set pointer = grant+1 (mod 3) and go to IDLE.
    - The next grant may be evaluated in the same cycle the eop is popped.
- m_sop/m_eop/m_port are stored alongside each byte in the buffer.
- Timeout:
  - In HDR/BODY, count consecutive cycles with vld_in[grant]=0; reset the count on any cycle with vld_in[grant]=1.
  - On reaching TIMEOUT: pulse abort, flush bytes of that packet still in the buffer (no eop is emitted), advance the pointer, go to IDLE.
- Backpressure: m_ready low for any length loses no data. m_data/m_sop/m_eop/m_port hold stable while m_valid && !m_ready.
- Simultaneous events:
  - vld_in change during a packet does not affect the grant.
  - Non-granted ports are never read.
- Reset mid-packet: immediately return to reset values; partially read packet bytes are discarded.
- L=0: BODY issues exactly 1 read (the parity byte).
- Header address bits are not checked against port index.

Decomposition:
- Shared package router_pkg:
  - state enum (IDLE, HDR, WAIT_HDR, BODY, DRAIN);
  - header field positions;
  - LEN_W=6;
  - NUM_PORTS=3.
- Sub-module router_skid_buf: 2-entry buffer, 12-bit entry {port,eop,sop,data}, push/pop/occupancy/flush.

Test Plan:
- Port 1, header 0x0D (L=3), payload 11 22 33, parity 0x0D^0x11^0x22^0x33=0x0D, m_ready=1 → read_enb_1 high 5 cycles; m_data 0D,11,22,33,0D; sop on first byte, eop on last; m_port=1; pkt_err=0.
- All vld_in=111 with one L=1 packet each, m_ready=1 → grant order 0,1,2,0; never two read_enb high; at most 1 idle cycle between packets.
- Same packet as the first scenario, m_ready low for 10 cycles after the 2nd byte → at most 2 bytes buffered; read_enb_1 low while stalled; output stays 0D,11,22,33,0D, no gap corruption.
- Port 2 header 0x02 (L=0), parity 0x03 → 2 bytes out; eop byte 0x03; pkt_err=1.
- Port 0 L=4, vld_in[0] drops after 2 payload bytes for 32 cycles → abort pulses once; no eop emitted; next port granted.
- reset asserted mid-BODY → same cycle all read_enb=0, m_valid=0; after release, the first vld_in is arbitrated from port 0.
